ascii_frame_tx: RTL and testbench

Parametrised ASCII frame encoder between the clock/sensor datapath and the UART TX FIFO. It snapshots a packed vector of BCD digits on a start pulse and converts each digit to ASCII. It inserts a separator character between fields and can append CR/LF. It pushes one byte per cycle into the FIFO, respects FIFO full without overflow, and queues one request that arrives while a frame is in flight.

---
 rtl/ascii_pkg.sv | 30 +++
 rtl/ascii_frame_sel.sv | 36 +++
 rtl/ascii_frame_tx.sv | 78 +++++++
 tb/tb_ascii_frame_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared constants and helpers for the ASCII frame encoder.
package ascii_pkg;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Bytes per frame: digits, separators between fields, optional CR/LF.
   function automatic int frame_len(input int nf, input int dpf, input int eol);
      return nf * dpf + (nf - 1) + ((eol != 0) ? 2 : 0);
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Non-decimal nibbles become '?' so a bad sensor code is visible on the line.
   function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (ASCII_0 + {4'b0000, d}) : ASCII_QMARK;
   endfunction

endpackage

// File: rtl/ascii_frame_sel.sv
// Combinational byte selector: maps a frame position to its ASCII byte.
module ascii_frame_sel
   import ascii_pkg::*;
#(
   parameter int          NUM_FIELDS       = 3,
   parameter int          DIGITS_PER_FIELD = 2,
   parameter logic [7:0]  SEP_CHAR         = ASCII_COLON,
   parameter int          EOL_EN           = 1,
   parameter int          IDX_W            = 4
) (
   input  logic [IDX_W-1:0]                          idx,
   input  logic [4*NUM_FIELDS*DIGITS_PER_FIELD-1:0]  snapshot,
   output logic [7:0]                                asciiByte
);

   localparam int ND    = NUM_FIELDS * DIGITS_PER_FIELD;
   localparam int EOL_P = ND + NUM_FIELDS - 1;

   // Each field occupies DIGITS_PER_FIELD+1 slots (digits then separator).
   always_comb begin
      asciiByte = 8'h00;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         for (int d = 0; d < DIGITS_PER_FIELD; d++) begin
            if (int'(idx) == f * (DIGITS_PER_FIELD + 1) + d)
               asciiByte = bcd2ascii(snapshot[4*ND-1-4*(f*DIGITS_PER_FIELD+d) -: 4]);
         end
         if (f < NUM_FIELDS - 1 && int'(idx) == f * (DIGITS_PER_FIELD + 1) + DIGITS_PER_FIELD)
            asciiByte = SEP_CHAR;
      end
      if (EOL_EN != 0) begin
         if (int'(idx) == EOL_P)     asciiByte = ASCII_CR;
         if (int'(idx) == EOL_P + 1) asciiByte = ASCII_LF;
      end
   end

endmodule

// File: rtl/ascii_frame_tx.sv
// ASCII frame encoder: snapshots BCD digits and streams them into the UART TX FIFO.
module ascii_frame_tx
   import ascii_pkg::*;
#(
   parameter int          NUM_FIELDS       = 3,
   parameter int          DIGITS_PER_FIELD = 2,
   parameter logic [7:0]  SEP_CHAR         = 8'h3A,
   parameter int          EOL_EN           = 1
) (
   input  logic                                      iClk,
   input  logic                                      iRst,
   input  logic                                      iStart,
   input  logic [4*NUM_FIELDS*DIGITS_PER_FIELD-1:0]  iDigits,
   input  logic                                      iFull,
   output logic                                      oPush,
   output logic [7:0]                                oAscii,
   output logic                                      oBusy,
   output logic                                      oDone,
   output logic                                      oOverrun
);

   localparam int ND    = NUM_FIELDS * DIGITS_PER_FIELD;
   localparam int L     = frame_len(NUM_FIELDS, DIGITS_PER_FIELD, EOL_EN);
   localparam int IDX_W = (clog2(L) < 1) ? 1 : clog2(L);

   logic [0:0]       state;
   logic [IDX_W-1:0] idx;
   logic             pending;
   logic [4*ND-1:0]  snapshot;
   logic [7:0]       selByte;
   logic             sending;
   logic             lastByte;

   ascii_frame_sel #(
      .NUM_FIELDS       (NUM_FIELDS),
      .DIGITS_PER_FIELD (DIGITS_PER_FIELD),
      .SEP_CHAR         (SEP_CHAR),
      .EOL_EN           (EOL_EN),
      .IDX_W            (IDX_W)
   ) uSel (
      .idx       (idx),
      .snapshot  (snapshot),
      .asciiByte (selByte)
   );

   // Push is gated by live iFull so the FIFO is never written while full.
   assign sending  = (state == ST_SEND);
   assign lastByte = (idx == IDX_W'(L - 1));
   assign oPush    = sending & ~iFull;
   assign oDone    = oPush & lastByte;
   assign oAscii   = sending ? selByte : 8'h00;
   assign oBusy    = sending | pending;
   assign oOverrun = sending & iStart & pending;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         pending  <= 1'b0;
         snapshot <= '0;
      end else if (!sending) begin
         // A pending launch consumes the queue slot; a coincident iStart refills it.
         if (iStart | pending) begin
            snapshot <= iDigits;
            idx      <= '0;
            state    <= ST_SEND;
            pending  <= iStart & pending;
         end
      end else begin
         if (oPush) begin
            if (lastByte) state <= ST_IDLE;
            else          idx   <= idx + 1'b1;
         end
         if (iStart) pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ascii_frame_tx.sv
// Self-checking bench for ascii_frame_tx: directed scenarios plus random traffic vs a frame-level model.
module tb_ascii_frame_tx;

   localparam int NF = 3, DPF = 2, ND = NF * DPF, EOL = 1;
   localparam logic [7:0] SEP = 8'h3A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, full;
   logic [4*ND-1:0] digits;
   logic          push, done, busy, ovr;
   logic [7:0]    ascii;

   logic          s2Start;
   logic [15:0]   s2Digits;
   logic          p2Push, p2Done, p2Busy, p2Ovr;
   logic [7:0]    p2Ascii;

   ascii_frame_tx dut (
      .iClk(clk), .iRst(rst), .iStart(start), .iDigits(digits), .iFull(full),
      .oPush(push), .oAscii(ascii), .oBusy(busy), .oDone(done), .oOverrun(ovr)
   );

   ascii_frame_tx #(.NUM_FIELDS(2), .DIGITS_PER_FIELD(2), .SEP_CHAR(8'h2E), .EOL_EN(0)) dut2 (
      .iClk(clk), .iRst(rst), .iStart(s2Start), .iDigits(s2Digits), .iFull(1'b0),
      .oPush(p2Push), .oAscii(p2Ascii), .oBusy(p2Busy), .oDone(p2Done), .oOverrun(p2Ovr)
   );

   int passed = 0, total = 0;
   int ovrCnt = 0, done2At = -1, pushInFull = 0;
   logic [7:0] cap[$];
   logic [7:0] cap2[$];

   // Frame-level model: current frame as a byte list, position in it, one queued request.
   bit         mActive = 0, mPend = 0;
   logic [7:0] mBytes[$];
   int         mPos = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void buildFrame(input logic [4*ND-1:0] dg);
      int nib;
      mBytes.delete();
      for (int k = 0; k < ND; k++) begin
         nib = int'((dg >> (4 * (ND - 1 - k))) & 'hF);
         mBytes.push_back(nib < 10 ? 8'(48 + nib) : 8'h3F);
         if ((k % DPF) == DPF - 1 && k != ND - 1) mBytes.push_back(SEP);
      end
      if (EOL) begin
         mBytes.push_back(8'h0D);
         mBytes.push_back(8'h0A);
      end
   endfunction

   task automatic step();
      logic ePush, eDone, eBusy, eOvr;
      logic [7:0] eAscii;
      @(negedge clk);
      ePush  = mActive && !full;
      eAscii = mActive ? mBytes[mPos] : 8'h00;
      eDone  = ePush && (mPos == mBytes.size() - 1);
      eBusy  = mActive || mPend;
      eOvr   = mActive && start && mPend;
      chk("oPush", 32'(push), 32'(ePush));
      chk("oAscii", 32'(ascii), 32'(eAscii));
      chk("oDone", 32'(done), 32'(eDone));
      chk("oBusy", 32'(busy), 32'(eBusy));
      chk("oOverrun", 32'(ovr), 32'(eOvr));
      if (push) cap.push_back(ascii);
      if (push && full) pushInFull++;
      if (ovr) ovrCnt++;
      if (p2Push) cap2.push_back(p2Ascii);
      if (p2Done) done2At = cap2.size();
      if (rst) begin
         mActive = 0; mPend = 0; mPos = 0;
      end else if (!mActive) begin
         if (start || mPend) begin
            buildFrame(digits);
            mPos = 0; mActive = 1;
            mPend = start && mPend;
         end
      end else begin
         if (ePush) begin
            if (mPos == mBytes.size() - 1) mActive = 0;
            else mPos++;
         end
         if (start) mPend = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chkList(input string tag, input logic [7:0] exp[$]);
      chk({tag, "_len"}, 32'(cap.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < cap.size(); i++)
         chk(tag, 32'(cap[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [7:0] f1[$];
      logic [7:0] f2[$];
      logic [7:0] f3[$];
      f1 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
      f2 = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
      f3 = '{8'h32, 8'h35, 8'h2E, 8'h37, 8'h35};
      rst = 1; start = 0; full = 0; digits = '0; s2Start = 0; s2Digits = '0;
      @(posedge clk); #1;
      steps(2);
      rst = 0;
      steps(1);

      // Single unstalled frame
      cap.delete(); digits = 24'h123456; start = 1;
      step(); start = 0;
      steps(11);
      chkList("frame1", f1);

      // Stall for 3 cycles after the 4th byte
      cap.delete(); pushInFull = 0; start = 1;
      step(); start = 0;
      steps(4);
      full = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", 32'(ascii), 32'h34);
      end
      full = 0;
      steps(8);
      chkList("stall", f1);
      chk("push_in_full", 32'(pushInFull), 32'd0);

      // Queued request with new digits during byte 5
      cap.delete(); ovrCnt = 0; start = 1;
      step(); start = 0;
      steps(4);
      start = 1; digits = 24'h235959;
      step(); start = 0;
      steps(18);
      chkList("queued", {f1, f2});
      chk("no_overrun", 32'(ovrCnt), 32'd0);

      // Two extra requests in one frame: one queued, one dropped
      cap.delete(); ovrCnt = 0; digits = 24'h123456; start = 1;
      step(); start = 0;
      steps(2); start = 1; step(); start = 0;
      steps(2); start = 1; step(); start = 0;
      steps(20);
      chk("overrun_cnt", 32'(ovrCnt), 32'd1);
      chk("two_frames", 32'(cap.size()), 32'd20);

      // Invalid digit then reset mid-frame
      cap.delete(); digits = 24'h1A3456; start = 1;
      step(); start = 0;
      steps(2);
      rst = 1; step(); rst = 0;
      steps(5);
      chk("qmark", 32'(cap[1]), 32'h3F);
      chk("abort_len", 32'(cap.size()), 32'd3);

      // Alternate configuration: 2x2 digits, '.', no EOL
      cap2.delete(); done2At = -1; s2Digits = 16'h2575; s2Start = 1;
      step(); s2Start = 0;
      steps(7);
      chk("cfg2_len", 32'(cap2.size()), 32'd5);
      for (int i = 0; i < 5 && i < cap2.size(); i++) chk("cfg2_byte", 32'(cap2[i]), 32'(f3[i]));
      chk("cfg2_done", 32'(done2At), 32'd5);

      // Random traffic against the model
      pushInFull = 0;
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom % 9) == 0;
         full  = ($urandom % 4) == 0;
         rst   = ($urandom % 250) == 0;
         if (($urandom % 5) == 0) digits = 24'($urandom);
         step();
      end
      start = 0; full = 0; rst = 0;
      steps(30);
      chk("rand_push_in_full", 32'(pushInFull), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
